// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline. It handles load-use stalls,
// taken-branch flushes resolved in MEM, and data-memory waits with a timeout.
module pipeline_hazard_ctrl #(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT       = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        mem_branch,
   input  logic        mem_zero,
   input  logic        mem_access,
   input  logic        dmem_ready,
   output logic        pc_write,
   output logic        pc_src,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        ex_mem_flush,
   output logic        pipe_hold,
   output logic        mem_wb_bubble,
   output logic        dmem_req,
   output logic        timeout_err,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      StRun       = 2'd0,
      StLoadStall = 2'd1,
      StMemWait   = 2'd2
   } state_e;

   localparam logic [1:0] LsLoad   = 2'(LOAD_STALL_CYCLES - 1);
   localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [1:0]  ls_cnt_q, ls_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;
   logic [15:0] stall_cnt_q, flush_cnt_q;
   logic        flush_evt;
   logic        run_eval;

   logic taken, load_use, wait_req;

   assign taken    = mem_branch & mem_zero;
   assign load_use = ex_mem_read & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
   assign wait_req = mem_access & ~dmem_ready;

   // Next-state and hazard outputs; reset forcing overrides everything at the end.
   always_comb begin
      pc_write      = 1'b1;
      pc_src        = 1'b0;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_flush  = 1'b0;
      pipe_hold     = 1'b0;
      mem_wb_bubble = 1'b0;
      dmem_req      = 1'b0;
      state_d       = state_q;
      ls_cnt_d      = ls_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_d     = timeout_q;
      flush_evt     = 1'b0;
      run_eval      = 1'b0;

      unique case (state_q)
         StRun: begin
            dmem_req = mem_access;
            run_eval = 1'b1;
         end
         StLoadStall: begin
            if (wait_req) begin
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               pipe_hold     = 1'b1;
               mem_wb_bubble = 1'b1;
               wait_cnt_d    = 8'd0;
               ls_cnt_d      = 2'd0;
               state_d       = StMemWait;
            end else if (taken) begin
               pc_src       = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               ex_mem_flush = 1'b1;
               flush_evt    = 1'b1;
               ls_cnt_d     = 2'd0;
               state_d      = StRun;
            end else begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               ls_cnt_d     = ls_cnt_q - 2'd1;
               if (ls_cnt_q == 2'd1) state_d = StRun;
            end
         end
         StMemWait: begin
            dmem_req = mem_access;
            if (!dmem_ready) begin
               if (wait_cnt_q == WaitLast) begin
                  // Give up: drop the request, bubble MEM/WB and let the pipe move.
                  dmem_req      = 1'b0;
                  mem_wb_bubble = 1'b1;
                  timeout_d     = 1'b1;
                  wait_cnt_d    = 8'd0;
                  state_d       = StRun;
               end else begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  pipe_hold     = 1'b1;
                  mem_wb_bubble = 1'b1;
                  wait_cnt_d    = wait_cnt_q + 8'd1;
               end
            end else begin
               // Access completes: the held EX/MEM branch (or a hazard) is handled as in RUN.
               state_d  = StRun;
               run_eval = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase

      if (run_eval) begin
         if (wait_req) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            pipe_hold     = 1'b1;
            mem_wb_bubble = 1'b1;
            wait_cnt_d    = 8'd0;
            state_d       = StMemWait;
         end else if (taken) begin
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            flush_evt    = 1'b1;
         end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
               ls_cnt_d = LsLoad;
               state_d  = StLoadStall;
            end
         end
      end

      if (!rst_n) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         pc_src        = 1'b0;
         dmem_req      = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_bubble  = 1'b1;
         ex_mem_flush  = 1'b1;
         mem_wb_bubble = 1'b1;
         pipe_hold     = 1'b0;
         flush_evt     = 1'b0;
      end
   end

   // State, internal counters and saturating statistics.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StRun;
         ls_cnt_q    <= 2'd0;
         wait_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         ls_cnt_q   <= ls_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
         if (!pc_write && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
         if (flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign timeout_err = timeout_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle vectors from RUN,
// followed by hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, mem_branch, mem_zero, mem_access, dmem_ready;

   logic        a_pc_write, a_pc_src, a_if_id_write, a_if_id_flush, a_id_ex_bubble;
   logic        a_ex_mem_flush, a_pipe_hold, a_mem_wb_bubble, a_dmem_req, a_timeout_err;
   logic [15:0] a_stall_count, a_flush_count;
   logic [1:0]  a_state;

   logic        b_pc_write, b_pc_src, b_if_id_write, b_if_id_flush, b_id_ex_bubble;
   logic        b_ex_mem_flush, b_pipe_hold, b_mem_wb_bubble, b_dmem_req, b_timeout_err;
   logic [15:0] b_stall_count, b_flush_count;
   logic [1:0]  b_state;

   logic [8:0] a_out;
   logic [8:0] b_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
      .mem_access(mem_access), .dmem_ready(dmem_ready),
      .pc_write(a_pc_write), .pc_src(a_pc_src), .if_id_write(a_if_id_write),
      .if_id_flush(a_if_id_flush), .id_ex_bubble(a_id_ex_bubble),
      .ex_mem_flush(a_ex_mem_flush), .pipe_hold(a_pipe_hold),
      .mem_wb_bubble(a_mem_wb_bubble), .dmem_req(a_dmem_req), .timeout_err(a_timeout_err),
      .stall_count(a_stall_count), .flush_count(a_flush_count), .state(a_state)
   );

   pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
      .mem_access(mem_access), .dmem_ready(dmem_ready),
      .pc_write(b_pc_write), .pc_src(b_pc_src), .if_id_write(b_if_id_write),
      .if_id_flush(b_if_id_flush), .id_ex_bubble(b_id_ex_bubble),
      .ex_mem_flush(b_ex_mem_flush), .pipe_hold(b_pipe_hold),
      .mem_wb_bubble(b_mem_wb_bubble), .dmem_req(b_dmem_req), .timeout_err(b_timeout_err),
      .stall_count(b_stall_count), .flush_count(b_flush_count), .state(b_state)
   );

   // {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
   //  pipe_hold, mem_wb_bubble, dmem_req}
   assign a_out = {a_pc_write, a_pc_src, a_if_id_write, a_if_id_flush, a_id_ex_bubble,
                   a_ex_mem_flush, a_pipe_hold, a_mem_wb_bubble, a_dmem_req};
   assign b_out = {b_pc_write, b_pc_src, b_if_id_write, b_if_id_flush, b_id_ex_bubble,
                   b_ex_mem_flush, b_pipe_hold, b_mem_wb_bubble, b_dmem_req};

   typedef struct {
      string      name;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       mem_read;
      logic [4:0] ert;
      logic       branch;
      logic       zero;
      logic       access;
      logic       ready;
      logic [8:0] exp_out;
      logic [1:0] exp_state;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
      mem_branch = 1'b0; mem_zero = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic set_load_use();
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
   endtask

   initial begin
      int n;
      //            name          rs  rt  urt rd ert br z  acc rdy  expected outputs  state
      vecs[0]  = '{"idle",        0,  0,  0,  0, 0,  0, 0, 0,  0,  9'b101000000,     2'd0};
      vecs[1]  = '{"lu_rs",       8,  0,  0,  1, 8,  0, 0, 0,  0,  9'b000010000,     2'd0};
      vecs[2]  = '{"lu_r0",       0,  0,  0,  1, 0,  0, 0, 0,  0,  9'b101000000,     2'd0};
      vecs[3]  = '{"rt_unused",   3,  8,  0,  1, 8,  0, 0, 0,  0,  9'b101000000,     2'd0};
      vecs[4]  = '{"lu_rt",       3,  8,  1,  1, 8,  0, 0, 0,  0,  9'b000010000,     2'd0};
      vecs[5]  = '{"taken",       0,  0,  0,  0, 0,  1, 1, 0,  0,  9'b111111000,     2'd0};
      vecs[6]  = '{"not_taken",   0,  0,  0,  0, 0,  1, 0, 0,  0,  9'b101000000,     2'd0};
      vecs[7]  = '{"access_rdy",  0,  0,  0,  0, 0,  0, 0, 1,  1,  9'b101000001,     2'd0};
      vecs[8]  = '{"access_wait", 0,  0,  0,  0, 0,  0, 0, 1,  0,  9'b000000111,     2'd2};
      vecs[9]  = '{"taken_lu",    8,  0,  0,  1, 8,  1, 1, 0,  0,  9'b111111000,     2'd0};
      vecs[10] = '{"all_three",   8,  0,  0,  1, 8,  1, 1, 1,  0,  9'b000000111,     2'd2};
      vecs[11] = '{"no_load",     8,  0,  0,  0, 8,  0, 0, 0,  0,  9'b101000000,     2'd0};

      idle_inputs();
      rst_n = 1'b0;
      step();

      // Reset-forced outputs and cleared state
      mem_access = 1'b1;
      @(negedge clk);
      check("reset_outputs", 32'(a_out), 32'(9'b000111010));
      check("reset_state", 32'(a_state), 32'd0);
      check("reset_counts", {a_stall_count, a_flush_count}, 32'd0);
      check("reset_timeout", 32'(a_timeout_err), 32'd0);
      idle_inputs();
      step();
      rst_n = 1'b1;

      // Single-cycle vectors, each from a freshly reset RUN state
      for (int i = 0; i < 12; i++) begin
         do_reset();
         id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
         ex_mem_read = vecs[i].mem_read; ex_rt = vecs[i].ert;
         mem_branch = vecs[i].branch; mem_zero = vecs[i].zero;
         mem_access = vecs[i].access; dmem_ready = vecs[i].ready;
         @(negedge clk);
         check({vecs[i].name, "_out"}, 32'(a_out), 32'(vecs[i].exp_out));
         step();
         check({vecs[i].name, "_state"}, 32'(a_state), 32'(vecs[i].exp_state));
         idle_inputs();
      end

      // One-cycle load-use with default parameters
      do_reset();
      set_load_use();
      step();
      idle_inputs();
      @(negedge clk);
      check("lu1_release", 32'(a_pc_write), 32'd1);
      check("lu1_stall_count", 32'(a_stall_count), 32'd1);
      check("lu1_state", 32'(a_state), 32'd0);

      // Two-cycle load-use stall
      do_reset();
      set_load_use();
      step();
      idle_inputs();
      @(negedge clk);
      check("lu2_state", 32'(b_state), 32'd1);
      check("lu2_hold_out", 32'(b_out), 32'(9'b000010000));
      step();
      check("lu2_done_state", 32'(b_state), 32'd0);
      check("lu2_stall_count", 32'(b_stall_count), 32'd2);
      check("lu2_run_out", 32'(b_out), 32'(9'b101000000));

      // Two-cycle load-use aborted by a taken branch in its second cycle
      do_reset();
      set_load_use();
      step();
      idle_inputs();
      mem_branch = 1'b1; mem_zero = 1'b1;
      @(negedge clk);
      check("lu2_taken_out", 32'(b_out), 32'(9'b111111000));
      step();
      idle_inputs();
      check("lu2_taken_state", 32'(b_state), 32'd0);
      check("lu2_taken_flush", 32'(b_flush_count), 32'd1);
      check("lu2_taken_stall", 32'(b_stall_count), 32'd1);

      // Memory wait of three cycles, released on the fourth
      do_reset();
      mem_access = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("wait_freeze", 32'(a_out), 32'(9'b000000111));
         step();
      end
      check("wait_state", 32'(a_state), 32'd2);
      dmem_ready = 1'b1;
      @(negedge clk);
      check("wait_release", 32'(a_out), 32'(9'b101000001));
      step();
      idle_inputs();
      check("wait_run", 32'(a_state), 32'd0);
      check("wait_stall_count", 32'(a_stall_count), 32'd3);

      // Timeout with MEM_TIMEOUT = 15
      do_reset();
      mem_access = 1'b1;
      n = 0;
      @(negedge clk);
      while (!a_pc_write && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("to_freeze_cycles", 32'(n), 32'd15);
      check("to_release_out", 32'(a_out), 32'(9'b101000010));
      mem_access = 1'b0;
      step();
      check("to_err", 32'(a_timeout_err), 32'd1);
      check("to_state", 32'(a_state), 32'd0);
      check("to_stall_count", 32'(a_stall_count), 32'd15);
      repeat (5) step();
      check("to_err_sticky", 32'(a_timeout_err), 32'd1);
      do_reset();
      check("to_err_cleared", 32'(a_timeout_err), 32'd0);

      // Timeout with MEM_TIMEOUT = 3
      mem_access = 1'b1;
      n = 0;
      @(negedge clk);
      while (!b_pc_write && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("to3_freeze_cycles", 32'(n), 32'd3);
      idle_inputs();
      step();
      check("to3_err", 32'(b_timeout_err), 32'd1);

      // Wait + taken + load-use together, then memory completes
      do_reset();
      set_load_use();
      mem_branch = 1'b1; mem_zero = 1'b1; mem_access = 1'b1;
      @(negedge clk);
      check("all_freeze", 32'(a_out), 32'(9'b000000111));
      step();
      check("all_state", 32'(a_state), 32'd2);
      dmem_ready = 1'b1;
      @(negedge clk);
      check("all_release_flush", 32'(a_out), 32'(9'b111111001));
      step();
      idle_inputs();
      check("all_state_run", 32'(a_state), 32'd0);
      check("all_flush_count", 32'(a_flush_count), 32'd1);
      check("all_stall_count", 32'(a_stall_count), 32'd1);

      // Reset in the middle of a load stall and a memory wait
      do_reset();
      set_load_use();
      step();
      idle_inputs();
      mem_access = 1'b1;
      step();
      check("mid_wait_state", 32'(a_state), 32'd2);
      idle_inputs();
      do_reset();
      @(negedge clk);
      check("mid_reset_a_state", 32'(a_state), 32'd0);
      check("mid_reset_a_out", 32'(a_out), 32'(9'b101000000));
      check("mid_reset_b_out", 32'(b_out), 32'(9'b101000000));

      // Saturation under a continuous stall
      do_reset();
      set_load_use();
      repeat (65540) step();
      check("stall_saturate", 32'(a_stall_count), 32'h0000_FFFF);
      step();
      check("stall_saturate_hold", 32'(a_stall_count), 32'h0000_FFFF);
      idle_inputs();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It takes hazard-relevant fields from the ID, EX and MEM stages and drives the PC and pipeline-register enables, flushes and bubbles. It handles three cases: load-use stalls, taken-branch flushes (branch resolved in MEM as `in_zero_flag & in_M[2]`), and multi-cycle data-memory waits with a timeout. It also keeps saturating stall and flush statistics for the testbench.

## Interface
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with MEM→EX forwarding, 2 without); legal 1..3
- MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before abort; legal 1..255
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_rs  in  5  rs of instruction in ID
- id_rt  in  5  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination rt of instruction in EX
- mem_branch  in  1  instruction in MEM is a branch (M[2])
- mem_zero  in  1  ALU zero flag latched in EX/MEM
- mem_access  in  1  MEM instruction reads or writes data memory
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC load enable
- pc_src  out  1  select branch target into PC
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  load NOP control into ID/EX
- ex_mem_flush  out  1  clear EX/MEM control
- pipe_hold  out  1  hold ID/EX and EX/MEM contents
- mem_wb_bubble  out  1  load NOP control into MEM/WB
- dmem_req  out  1  data memory access request
- timeout_err  out  1  sticky memory-timeout flag
- stall_count  out  16  saturating count of stall cycles
- flush_count  out  16  saturating count of taken-branch flushes
- state  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT

## Operation
- `taken = mem_branch & mem_zero`
- `load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))`
- `wait_req = mem_access & ~dmem_ready`
- Default outputs: `pc_write = 1`, `if_id_write = 1`, all flush, bubble and hold outputs 0, `pc_src = 0`.
- `dmem_req = mem_access` in RUN and MEM_WAIT; otherwise 0.
- Priority in every state: reset > wait_req > taken > load_use.
- RUN:
  - If `wait_req`: freeze the pipeline (`pc_write = 0`, `if_id_write = 0`, `pipe_hold = 1`, `mem_wb_bubble = 1`), clear the wait counter, go to MEM_WAIT.
  - Else if `taken`: `pc_src = 1`, `if_id_flush = 1`, `id_ex_bubble = 1`, `ex_mem_flush = 1`, increment flush_count, stay in RUN.
  - Else if `load_use`: `pc_write = 0`, `if_id_write = 0`, `id_ex_bubble = 1`. If LOAD_STALL_CYCLES > 1, load the counter with LOAD_STALL_CYCLES−1 and go to LOAD_STALL.
- LOAD_STALL:
  - Drive the same stall outputs as a load-use stall and decrement the counter.
  - Return to RUN in the cycle the counter reaches 0.
  - If `taken` in this state: flush as in RUN, abort the stall, go to RUN.
- MEM_WAIT:
  - Drive freeze outputs while `~dmem_ready`, and increment the wait counter.
  - On `dmem_ready`: default outputs this cycle, with `taken` honored if present (branch in held EX/MEM); go to RUN.
  - If the wait counter reaches MEM_TIMEOUT without ready: set timeout_err, force `dmem_req = 0` and `mem_wb_bubble = 1` this cycle, release the freeze, go to RUN.
- stall_count increments in every cycle where `pc_write == 0`. Both counters saturate at 0xFFFF.

## Timing
- Hazard outputs are combinational from state and inputs in the same cycle. State and counters are registered.
- Load-use costs exactly LOAD_STALL_CYCLES cycles of `pc_write = 0`.
- Taken branch costs 3 flushed slots with a single-cycle flush pulse.
- Reset (`rst_n` low at an edge): state → RUN, both counters → 0, timeout_err → 0, internal counters → 0.
- While `rst_n` is low, outputs are forced: `pc_write = 0`, `if_id_write = 0`, `pc_src = 0`, `dmem_req = 0`; `if_id_flush`, `id_ex_bubble`, `ex_mem_flush` and `mem_wb_bubble` = 1; `pipe_hold = 0`.
- Reset mid-MEM_WAIT or mid-LOAD_STALL aborts to RUN with no residual stall.
- timeout_err clears only on reset.

## Test plan
- Load-use, default params: `ex_mem_read = 1`, `ex_rt = 8`, `id_rs = 8` for one cycle → `pc_write = 0`, `id_ex_bubble = 1` for 1 cycle; `stall_count = 1`; state stays 0.
- `ex_rt = 0` with `id_rs = 0` → no stall. With `id_rt = 8`, `id_uses_rt = 0` → no stall.
- LOAD_STALL_CYCLES = 2: load-use, then `taken` in the 2nd cycle → flush pulse; back to RUN; `flush_count = 1`; `stall_count = 1`.
- `mem_access = 1` with `dmem_ready` low for 3 cycles then high → freeze for 3 cycles; release on the 4th; `stall_count = 3`.
- `dmem_ready` never asserted, MEM_TIMEOUT = 15 → freeze for 15 cycles, then timeout_err = 1, `mem_wb_bubble = 1`, `dmem_req = 0`; RUN. timeout_err remains 1 until `rst_n` = 0.
- Simultaneous `taken` + `load_use` + `wait_req` → freeze only. On `dmem_ready`: flush with `pc_src = 1` and no load stall. Counters saturate at 0xFFFF under a continuous stall.
